// File: rtl/pid_core_mc.sv
// pid_core_mc: time-multiplexed multi-channel PID core.
// Channels share one multiplier. Each sample walks ERR -> P -> I -> D -> SUM -> OUT.
// Target and gains are snapshotted at accept, so a config write made mid-flight
// only affects that channel's next sample.
module pid_core_mc #(
  parameter int NCH         = 2,
  parameter int DW          = 12,
  parameter int GW          = 12,
  parameter int FRAC        = 6,
  parameter int IW          = 20,
  parameter int OW          = 16,
  parameter int INT_LIM     = 4096,
  parameter int TARGET_INIT = 1024,
  parameter int KP_INIT     = 0,
  parameter int KI_INIT     = 0,
  parameter int KD_INIT     = 0,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_ch,
  input  logic [DW-1:0] s_meas,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [1:0]    cfg_sel,
  input  logic [GW-1:0] cfg_data,
  input  logic          clr_int,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_ch,
  output logic [OW-1:0] m_out,
  output logic          m_sat
);

  localparam int EW  = DW + 1;       // error width
  localparam int DEW = DW + 2;       // error-delta width
  localparam int SW  = IW + GW + 3;  // sum width

  localparam logic signed [IW:0]   LIM_P   = (IW+1)'(INT_LIM);
  localparam logic signed [IW:0]   LIM_N   = -LIM_P;
  localparam logic signed [SW-1:0] OUT_MAX = SW'((longint'(1) <<< (OW-1)) - longint'(1));
  localparam logic signed [SW-1:0] OUT_MIN = -OUT_MAX - SW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_P, S_I, S_D, S_SUM, S_OUT, S_DROP
  } state_t;

  state_t state_reg, state_next;
  logic   s_ready_reg, s_ready_next;
  logic   m_valid_reg;

  // Per-channel configuration and loop state
  logic [DW-1:0]          target_reg [NCH];
  logic [GW-1:0]          kp_reg     [NCH];
  logic [GW-1:0]          ki_reg     [NCH];
  logic [GW-1:0]          kd_reg     [NCH];
  logic signed [IW-1:0]   integ_reg  [NCH];
  logic signed [EW-1:0]   prev_e_reg [NCH];
  logic                   sat_pos_reg[NCH];
  logic                   sat_neg_reg[NCH];

  // Snapshot and pipeline registers for the sample in flight
  logic [CW-1:0]          ch_reg;
  logic [DW-1:0]          meas_reg;
  logic [DW-1:0]          tgt_s_reg;
  logic [GW-1:0]          kp_s_reg, ki_s_reg, kd_s_reg;
  logic signed [EW-1:0]   e_reg;
  logic signed [DEW-1:0]  de_reg;
  logic signed [IW-1:0]   acc_reg;
  logic signed [SW-1:0]   p_reg, i_reg, d_reg;
  logic [OW-1:0]          m_out_reg;
  logic                   m_sat_reg;
  logic [CW-1:0]          m_ch_reg;

  logic                   accept;
  logic                   ch_ok;
  logic [CW-1:0]          s_idx;
  logic [NCH-1:0]         cfg_hit;
  logic [NCH-1:0]         wb_hit;

  assign accept = s_valid && s_ready_reg;
  assign ch_ok  = int'(s_ch) < NCH;
  assign s_idx  = ch_ok ? s_ch : '0;

  // Per-channel write decode for config writes and SUM writeback
  for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
    assign cfg_hit[gi] = cfg_we && (cfg_ch == CW'(gi));
    assign wb_hit[gi]  = (state_reg == S_SUM) && (ch_reg == CW'(gi));
  end

  // Error terms (valid in ERR)
  logic signed [EW-1:0] e_calc;
  assign e_calc = $signed({1'b0, tgt_s_reg}) - $signed({1'b0, meas_reg});

  // Integrator update with anti-windup and clamping (valid in I)
  logic                 skip_int;
  logic signed [IW:0]   acc_wide;
  logic signed [IW-1:0] acc_clamped;
  assign skip_int = (sat_pos_reg[ch_reg] && !e_reg[EW-1] && (e_reg != '0)) ||
                    (sat_neg_reg[ch_reg] && e_reg[EW-1]);

  // Integrator candidate: hold while pushing further into saturation, then clamp
  always_comb begin
    acc_wide = (IW+1)'(integ_reg[ch_reg]);
    if (!skip_int) begin
      acc_wide = acc_wide + (IW+1)'(e_reg);
    end
    acc_clamped = IW'(acc_wide);
    if (acc_wide > LIM_P) begin
      acc_clamped = IW'(LIM_P);
    end else if (acc_wide < LIM_N) begin
      acc_clamped = IW'(LIM_N);
    end
  end

  // Shared multiplier operand select
  logic [GW-1:0]        mul_a;
  logic signed [IW-1:0] mul_b;
  logic signed [SW-1:0] mul_p;
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      S_P: begin mul_a = kp_s_reg; mul_b = IW'(e_reg);  end
      S_I: begin mul_a = ki_s_reg; mul_b = acc_clamped; end
      S_D: begin mul_a = kd_s_reg; mul_b = IW'(de_reg); end
      default: ;
    endcase
  end
  assign mul_p = SW'($signed({1'b0, mul_a})) * SW'(mul_b);

  // Sum, scale and output clamp (valid in SUM)
  logic signed [SW-1:0] sum_full, sum_sh;
  logic                 sum_pos, sum_neg;
  logic [OW-1:0]        sum_clamped;
  assign sum_full = p_reg + i_reg + d_reg;
  assign sum_sh   = sum_full >>> FRAC;
  assign sum_pos  = sum_sh > OUT_MAX;
  assign sum_neg  = sum_sh < OUT_MIN;
  assign sum_clamped = sum_pos ? OW'(OUT_MAX) : (sum_neg ? OW'(OUT_MIN) : OW'(sum_sh));

  // Next-state and ready decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = ch_ok ? S_ERR : S_DROP;
      S_ERR:  state_next = S_P;
      S_P:    state_next = S_I;
      S_I:    state_next = S_D;
      S_D:    state_next = S_SUM;
      S_SUM:  state_next = S_OUT;
      S_OUT:  if (m_valid_reg && m_ready) state_next = S_IDLE;
      S_DROP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    s_ready_next = (state_next == S_IDLE);
  end

  // State register; ready is registered so it is low through the reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      s_ready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= s_ready_next;
    end
  end

  // Per-channel config writes, writeback and clear (clear wins over writeback)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        target_reg[c]  <= DW'(TARGET_INIT);
        kp_reg[c]      <= GW'(KP_INIT);
        ki_reg[c]      <= GW'(KI_INIT);
        kd_reg[c]      <= GW'(KD_INIT);
        integ_reg[c]   <= '0;
        prev_e_reg[c]  <= '0;
        sat_pos_reg[c] <= 1'b0;
        sat_neg_reg[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_hit[c]) begin
          case (cfg_sel)
            2'd0: target_reg[c] <= DW'(cfg_data);
            2'd1: kp_reg[c]     <= cfg_data;
            2'd2: ki_reg[c]     <= cfg_data;
            default: kd_reg[c]  <= cfg_data;
          endcase
        end
        if (clr_int) begin
          integ_reg[c]   <= '0;
          prev_e_reg[c]  <= '0;
          sat_pos_reg[c] <= 1'b0;
          sat_neg_reg[c] <= 1'b0;
        end else if (wb_hit[c]) begin
          integ_reg[c]   <= acc_reg;
          prev_e_reg[c]  <= e_reg;
          sat_pos_reg[c] <= sum_pos;
          sat_neg_reg[c] <= sum_neg;
        end
      end
    end
  end

  // Datapath pipeline: snapshot at accept, one stage per state, result at SUM
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_reg    <= '0;
      meas_reg  <= '0;
      tgt_s_reg <= '0;
      kp_s_reg  <= '0;
      ki_s_reg  <= '0;
      kd_s_reg  <= '0;
      e_reg     <= '0;
      de_reg    <= '0;
      acc_reg   <= '0;
      p_reg     <= '0;
      i_reg     <= '0;
      d_reg     <= '0;
      m_out_reg <= '0;
      m_sat_reg <= 1'b0;
      m_ch_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept && ch_ok) begin
            ch_reg    <= s_ch;
            meas_reg  <= s_meas;
            tgt_s_reg <= target_reg[s_idx];
            kp_s_reg  <= kp_reg[s_idx];
            ki_s_reg  <= ki_reg[s_idx];
            kd_s_reg  <= kd_reg[s_idx];
          end
        end
        S_ERR: begin
          e_reg  <= e_calc;
          de_reg <= DEW'(e_calc) - DEW'(prev_e_reg[ch_reg]);
        end
        S_P: p_reg <= mul_p;
        S_I: begin
          i_reg   <= mul_p;
          acc_reg <= acc_clamped;
        end
        S_D: d_reg <= mul_p;
        S_SUM: begin
          m_out_reg <= sum_clamped;
          m_sat_reg <= sum_pos || sum_neg;
          m_ch_reg  <= ch_reg;
        end
        default: ;
      endcase
    end
  end

  // Result valid: raised one cycle into OUT, held until the downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
    end else if (state_reg == S_OUT && !m_valid_reg) begin
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = m_valid_reg;
  assign m_ch    = m_ch_reg;
  assign m_out   = m_out_reg;
  assign m_sat   = m_sat_reg;

endmodule

// File: tb/tb_pid_core_mc.sv
// tb_pid_core_mc: directed and randomized checks of pid_core_mc against a
// plain-arithmetic reference model. NCH=3 so an out-of-range channel code exists.
module tb_pid_core_mc;

  localparam int NCH  = 3;
  localparam int CW   = 2;
  localparam int DW   = 12;
  localparam int GW   = 12;
  localparam int FRAC = 6;
  localparam int OW   = 16;
  localparam longint INT_LIM = 4096;
  localparam longint OMAX    = 32767;
  localparam longint OMIN    = -32768;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] s_ch;
  logic [DW-1:0] s_meas;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_sel;
  logic [GW-1:0] cfg_data;
  logic          clr_int;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] m_ch;
  logic [OW-1:0] m_out;
  logic          m_sat;

  pid_core_mc #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_meas(s_meas),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .clr_int(clr_int),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_out(m_out), .m_sat(m_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_tgt[NCH], m_kp[NCH], m_ki[NCH], m_kd[NCH];
  longint m_integ[NCH], m_prev[NCH];
  int     m_sdir[NCH];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 1024; m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0;
      m_integ[c] = 0; m_prev[c] = 0; m_sdir[c] = 0;
    end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_integ[c] = 0; m_prev[c] = 0; m_sdir[c] = 0;
    end
  endfunction

  function automatic void model_cfg(input int ch, input int sel, input int data);
    case (sel)
      0: m_tgt[ch] = longint'(data % 4096);
      1: m_kp[ch]  = longint'(data);
      2: m_ki[ch]  = longint'(data);
      default: m_kd[ch] = longint'(data);
    endcase
  endfunction

  // One PID step straight from the control law
  function automatic void model_run(input int ch, input int meas, output longint out, output bit sat);
    longint e, de, acc, pt, it, dt, s;
    e  = m_tgt[ch] - longint'(meas);
    de = e - m_prev[ch];
    pt = m_kp[ch] * e;
    acc = m_integ[ch];
    if (!((m_sdir[ch] == 1 && e > 0) || (m_sdir[ch] == -1 && e < 0))) acc = acc + e;
    if (acc > INT_LIM)  acc = INT_LIM;
    if (acc < -INT_LIM) acc = -INT_LIM;
    it = m_ki[ch] * acc;
    dt = m_kd[ch] * de;
    s  = (pt + it + dt) >>> FRAC;
    sat = 1'b0;
    m_sdir[ch] = 0;
    if (s > OMAX) begin s = OMAX; sat = 1'b1; m_sdir[ch] = 1; end
    else if (s < OMIN) begin s = OMIN; sat = 1'b1; m_sdir[ch] = -1; end
    m_integ[ch] = acc;
    m_prev[ch]  = e;
    out = s;
  endfunction

  task automatic cfg_write(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 2'(sel); cfg_data = GW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(ch, sel, data);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_int = 1'b1;
    @(negedge clk);
    clr_int = 1'b0;
    model_clear();
  endtask

  // Send one sample and check the result.
  // mid: 0 none, 1 config write while in flight, 2 clr_int during SUM.
  task automatic run_sample(input int ch, input int meas, input int hold, input int mid,
                            input int mid_ch, input int mid_sel, input int mid_data,
                            output longint got);
    longint        exp_out;
    bit            exp_sat;
    int            lat;
    bit            seen;
    logic [OW-1:0] h_out;
    logic [CW-1:0] h_ch;
    model_run(ch, meas, exp_out, exp_sat);
    if (mid == 1) model_cfg(mid_ch, mid_sel, mid_data);
    if (mid == 2) model_clear();
    @(negedge clk);
    for (int k = 0; k < 20 && s_ready !== 1'b1; k++) @(negedge clk);
    chk("ready_before_accept", s_ready, 1);
    s_valid = 1'b1; s_ch = CW'(ch); s_meas = DW'(meas);
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mid == 1 && k == 1) begin
        cfg_we = 1'b1; cfg_ch = CW'(mid_ch); cfg_sel = 2'(mid_sel); cfg_data = GW'(mid_data);
      end
      if (mid == 1 && k == 2) cfg_we = 1'b0;
      if (mid == 2 && k == 4) clr_int = 1'b1;
      if (mid == 2 && k == 5) clr_int = 1'b0;
      if (m_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    cfg_we = 1'b0; clr_int = 1'b0;
    chk("latency", lat, 6);
    @(negedge clk);
    chk("m_ch", m_ch, ch);
    chk("m_out", $signed(m_out), exp_out);
    chk("m_sat", m_sat, exp_sat);
    got = longint'($signed(m_out));
    $display("sample ch=%0d meas=%0d out=%0d sat=%0d expect=%0d/%0d", ch, meas, got, m_sat, exp_out, exp_sat);
    if (hold > 0) begin
      h_out = m_out; h_ch = m_ch;
      s_valid = 1'b1; s_ch = '0; s_meas = '0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_m_out", m_out, h_out);
        chk("hold_m_ch", m_ch, h_ch);
        chk("hold_m_valid", m_valid, 1);
        chk("hold_s_ready", s_ready, 0);
      end
      s_valid = 1'b0;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("valid_after_xfer", m_valid, 0);
    chk("ready_after_xfer", s_ready, 1);
    if (hold > 0) begin
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (m_valid !== 1'b0) seen = 1'b1;
      end
      chk("no_accept_during_hold", seen, 0);
    end
  endtask

  task automatic smp(input int ch, input int meas, output longint got);
    run_sample(ch, meas, 0, 0, 0, 0, 0, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got;
    bit     seen;
    rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_meas = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    clr_int = 1'b0; m_ready = 1'b0;
    model_reset();

    // 1. Reset state and a pure-P sample
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_out", m_out, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_m_sat", m_sat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_s_ready_hold", s_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_s_ready", s_ready, 1);
    cfg_write(0, 1, 64);
    cfg_write(0, 0, 1000);
    smp(0, 900, got);
    chk("p_only", got, 100);

    // 2. Pure-I accumulation and clear
    pulse_clr();
    cfg_write(0, 1, 0);
    cfg_write(0, 2, 64);
    smp(0, 990, got); chk("i_step1", got, 10);
    smp(0, 990, got); chk("i_step2", got, 20);
    smp(0, 990, got); chk("i_step3", got, 30);
    pulse_clr();
    smp(0, 990, got); chk("i_after_clr", got, 10);

    // 3. Pure-D
    pulse_clr();
    cfg_write(0, 2, 0);
    cfg_write(0, 3, 64);
    smp(0, 900, got); chk("d_step1", got, 100);
    smp(0, 950, got); chk("d_step2", got, -50);

    // 4. Output saturation and anti-windup
    pulse_clr();
    cfg_write(0, 3, 0);
    cfg_write(0, 1, 4095);
    cfg_write(0, 0, 4095);
    smp(0, 0, got); chk("sat_pos_out", got, 32767);
    cfg_write(0, 2, 64);
    smp(0, 0, got);
    smp(0, 0, got);
    smp(0, 0, got);
    cfg_write(0, 0, 0);
    smp(0, 100, got); chk("unwind_negative", got < 0, 1);
    smp(0, 100, got);

    // 5. Backpressure hold
    run_sample(0, 50, 10, 0, 0, 0, 0, got);

    // 6. Interleaved channels, mid-flight config, clear during SUM
    pulse_clr();
    cfg_write(0, 1, 0);
    cfg_write(0, 0, 1000);
    cfg_write(0, 2, 64);
    cfg_write(1, 0, 2000);
    cfg_write(1, 2, 64);
    smp(0, 990, got);  chk("ilv_c0_a", got, 10);
    smp(1, 1990, got); chk("ilv_c1_a", got, 10);
    smp(0, 990, got);  chk("ilv_c0_b", got, 20);
    run_sample(1, 1990, 0, 1, 1, 2, 128, got); chk("ilv_c1_b", got, 20);
    smp(1, 1990, got); chk("ilv_c1_newki", got, 60);
    run_sample(0, 990, 0, 2, 0, 0, 0, got); chk("clr_in_sum_delivered", got, 30);
    smp(0, 990, got); chk("clr_in_sum_wins", got, 10);

    // Out-of-range channel is swallowed
    @(negedge clk);
    s_valid = 1'b1; s_ch = 2'd3; s_meas = 12'd500;
    @(posedge clk); #1;
    s_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) seen = 1'b1;
    end
    chk("drop_no_output", seen, 0);
    chk("drop_ready", s_ready, 1);
    smp(0, 990, got); chk("drop_no_state_change", got, 20);

    // Reset while in D aborts the sample and restores defaults
    @(negedge clk);
    s_valid = 1'b1; s_ch = 2'd1; s_meas = 12'd700;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_output", seen, 0);
    smp(0, 1000, got); chk("reset_gains_zero", got, 0);
    cfg_write(0, 2, 64);
    smp(0, 1000, got); chk("reset_integ_cleared", got, 48);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) cfg_write(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      else if (r == 3) pulse_clr();
      smp(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 4095)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_core_mc.md
Name: pid_core_mc

Overview:
Time-multiplexed, multi-channel PID core that replaces the single-loop PID datapath in the PSU controller.
- Accepts tagged ADC samples over a valid/ready stream.
- Computes a saturated signed control word per channel with per-channel target, gains, integrator and derivative history.
- Provides integrator anti-windup and output clamping, which the single-loop datapath lacks.
- Sits between the SPI ADC receiver and the PWM control blocks; one shared multiplier serves all channels.

Parameters:
NCH, 2, number of channels (>=1)
DW, 12, measurement width (unsigned)
GW, 12, gain width (unsigned fixed point, FRAC fractional bits)
FRAC, 6, gain fractional bits; product shift
IW, 20, integrator width (signed)
OW, 16, output width (signed)
INT_LIM, 4096, integrator clamp magnitude (< 2^(IW-1))
TARGET_INIT, 1024, reset target, all channels
KP_INIT / KI_INIT / KD_INIT, 0, reset gains, all channels

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  sample valid
s_ready  out  1  core idle, can accept
s_ch  in  max(1,$clog2(NCH))  sample channel
s_meas  in  DW  measured value
cfg_we  in  1  config write strobe
cfg_ch  in  max(1,$clog2(NCH))  config channel
cfg_sel  in  2  0=target, 1=kp, 2=ki, 3=kd
cfg_data  in  GW  config value (target uses low DW bits)
clr_int  in  1  clear all integrators and derivative history
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_ch  out  max(1,$clog2(NCH))  result channel
m_out  out  OW  signed control word
m_sat  out  1  m_out was clamped

Behaviour:
- Reset:
  - Outputs: s_ready=0 during the reset cycle, then 1 (IDLE). m_valid=0, m_ch=0, m_out=0, m_sat=0.
  - Per-channel state: integrators=0, prev_e=0, sat_dir=0, targets=TARGET_INIT, gains=*_INIT.
  - Reset mid-operation aborts the sample; no m_valid.
- FSM: IDLE -> ERR -> P -> I -> D -> SUM -> OUT -> IDLE. One cycle per state except OUT.
- s_ready=1 only in IDLE. Handshake s_valid&s_ready latches s_ch, s_meas, and that channel's target and gains (snapshot).
- Latency: m_valid rises 6 clock edges after the accept edge. m_valid, m_ch, m_out and m_sat are held stable until m_valid&m_ready. Transfer returns to IDLE; next accept is possible in the following cycle.
- s_ch >= NCH: sample accepted and discarded; return to IDLE next cycle; no output, no state change.
- ERR:
  - e = target - meas, signed DW+1.
  - de = e - prev_e[ch], signed DW+2.
- P: p = kp*e.
- I:
  - acc = integ[ch] + e.
  - Skip the update (acc = integ[ch]) when sat_dir[ch]=+1 and e>0, or sat_dir[ch]=-1 and e<0 (anti-windup).
  - Clamp acc to [-INT_LIM, +INT_LIM]. i = ki*acc.
- D: d = kd*de.
- SUM:
  - s = (p+i+d) >>> FRAC, arithmetic, full width IW+GW+3.
  - Clamp s to [-2^(OW-1), 2^(OW-1)-1]; m_sat=1 if clamped.
  - sat_dir[ch] = +1/-1/0 per clamp direction.
- Writeback at SUM: integ[ch]=acc, prev_e[ch]=e.
- cfg_we: writes the selected register in the same cycle, any state. A write to the channel in flight affects only the next sample (snapshot rule).
- clr_int: zeroes all integ, prev_e and sat_dir the next edge; it wins over a same-cycle SUM writeback. The in-flight result is still delivered.
- Signed gains are not supported; gains are always non-negative.

Test Plan:
1. Reset, then ch0 kp=64, ki=kd=0, target=1000, meas=900 -> s_ready=0 in reset cycle then 1; m_valid 6 edges after accept, m_ch=0, m_out=100, m_sat=0.
2. kp=0, ki=64, kd=0, target=1000, three samples meas=990 -> m_out=10, 20, 30. Assert clr_int, next sample -> 10.
3. kd=64, kp=ki=0, target=1000, meas=900 then 950 -> m_out=100 then -50 (prev_e starts at 0).
4. kp=4095, target=4095, meas=0 -> m_out=32767, m_sat=1. With ki=64 added, repeated samples leave the integrator unchanged while saturated. Drive target=0 -> m_out negative, integrator unwinds from its held value.
5. Hold m_ready=0 for 10 cycles with result pending -> m_out/m_ch stable, s_ready=0, new s_valid not accepted. Release -> one transfer, s_ready=1 next cycle.
6. Interleave ch0 (target=1000) and ch1 (target=2000), ki=64, meas=990 / 1990 -> independent outputs 10, 10, 20, 20. cfg write ki=128 to ch1 during ch1 processing -> applies from the next ch1 sample. s_ch=2 with NCH=2 -> no output. Reset during the D state -> no m_valid, all state cleared.
